// File: rtl/dm_mem_pkg.sv
// Shared types for the debug-module data-memory access master: FSM states,
// default memory depth and burst-beat counter type.
`timescale 1ns/1ps
package dm_mem_pkg;

  localparam int DM_MEM_DEPTH = 32;
  localparam int DM_LEN_W     = 4;

  typedef logic [DM_LEN_W-1:0] dm_beat_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_CAPT,
    ST_RD_RSP,
    ST_WR_DRIVE,
    ST_WR_RSP
  } dm_acc_state_e;

  function automatic logic dm_in_range(input logic [31:0] addr, input int depth);
    return addr < 32'(depth);
  endfunction

endpackage

// File: rtl/dm_mem_access_master.sv
// Debug-port initiator to data memory: single-word writes (2 cycles) and burst reads (3 cycles/beat);
// requests accepted only when idle, responses held stable until rsp_ready_i.
`timescale 1ns/1ps
module dm_mem_access_master
  import dm_mem_pkg::*;
#(
  parameter int MEM_DEPTH = DM_MEM_DEPTH,
  parameter int LEN_W     = DM_LEN_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_write_i,
  input  logic [31:0]      req_addr_i,
  input  logic [31:0]      req_wdata_i,
  input  logic [LEN_W-1:0] req_len_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_rdata_o,
  output logic             rsp_err_o,
  output logic             rsp_last_o,
  output logic             busy_o,
  output logic             dm_Mem_rd_en_o,
  output logic             dm_Mem_wr_en_o,
  output logic [31:0]      dm_Mem_rd_address_o,
  inout  wire  [31:0]      dm_Mem_rd_wr_data_io
);

  dm_acc_state_e    state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             last_q, last_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             req_ready_q, req_ready_d;
  logic             rd_en_q, rd_en_d;
  logic             wr_en_q, wr_en_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      nxt_addr;

  assign nxt_addr = addr_q + 32'd1;

  // Bus ownership follows the state register, so async reset releases it immediately.
  assign dm_Mem_rd_wr_data_io = (state_q == ST_WR_DRIVE) ? wdata_q : 'z;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    len_d       = len_q;
    beat_d      = beat_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    last_d      = last_q;
    rsp_valid_d = rsp_valid_q;
    req_ready_d = req_ready_q;
    rd_en_d     = rd_en_q;
    wr_en_d     = wr_en_q;
    mem_addr_d  = mem_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          addr_d      = req_addr_i;
          wdata_d     = req_wdata_i;
          len_d       = req_write_i ? '0 : req_len_i;
          beat_d      = '0;
          req_ready_d = 1'b0;
          if (!dm_in_range(req_addr_i, MEM_DEPTH)) begin
            state_d     = req_write_i ? ST_WR_RSP : ST_RD_RSP;
            rsp_valid_d = 1'b1;
            rdata_d     = '0;
            err_d       = 1'b1;
            last_d      = 1'b1;
          end else if (req_write_i) begin
            state_d    = ST_WR_DRIVE;
            wr_en_d    = 1'b1;
            mem_addr_d = req_addr_i;
          end else begin
            state_d    = ST_RD_ADDR;
            rd_en_d    = 1'b1;
            mem_addr_d = req_addr_i;
          end
        end
      end
      ST_RD_ADDR: state_d = ST_RD_CAPT;
      ST_RD_CAPT: begin
        state_d     = ST_RD_RSP;
        rdata_d     = dm_Mem_rd_wr_data_io;
        rd_en_d     = 1'b0;
        mem_addr_d  = '0;
        rsp_valid_d = 1'b1;
        err_d       = 1'b0;
        last_d      = (beat_q == len_q);
      end
      ST_RD_RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          rdata_d     = '0;
          err_d       = 1'b0;
          last_d      = 1'b0;
          if (last_q) begin
            state_d     = ST_IDLE;
            req_ready_d = 1'b1;
          end else begin
            addr_d = nxt_addr;
            beat_d = beat_q + LEN_W'(1);
            if (dm_in_range(nxt_addr, MEM_DEPTH)) begin
              state_d    = ST_RD_ADDR;
              rd_en_d    = 1'b1;
              mem_addr_d = nxt_addr;
            end else begin
              // Out-of-range beat terminates the burst without touching memory.
              rsp_valid_d = 1'b1;
              err_d       = 1'b1;
              last_d      = 1'b1;
            end
          end
        end
      end
      ST_WR_DRIVE: begin
        state_d     = ST_WR_RSP;
        wr_en_d     = 1'b0;
        mem_addr_d  = '0;
        rsp_valid_d = 1'b1;
        rdata_d     = '0;
        err_d       = 1'b0;
        last_d      = 1'b1;
      end
      ST_WR_RSP: begin
        if (rsp_ready_i) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          err_d       = 1'b0;
          last_d      = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;
        mem_addr_d  = '0;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      last_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  assign req_ready_o         = req_ready_q;
  assign rsp_valid_o         = rsp_valid_q;
  assign rsp_rdata_o         = rdata_q;
  assign rsp_err_o           = err_q;
  assign rsp_last_o          = last_q;
  assign busy_o              = (state_q != ST_IDLE);
  assign dm_Mem_rd_en_o      = rd_en_q;
  assign dm_Mem_wr_en_o      = wr_en_q;
  assign dm_Mem_rd_address_o = mem_addr_q;

endmodule

// File: tb/tb_dm_mem_access_master.sv
// Bench for dm_mem_access_master: bus-attached memory model, request-level reference
// model feeding a response scoreboard, and a per-cycle monitor.
`timescale 1ns/1ps
module tb_dm_mem_access_master;
  import dm_mem_pkg::*;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  dm_beat_t    req_len = '0;
  logic        rsp_ready = 1'b0;
  logic        req_ready, rsp_valid, rsp_err, rsp_last, busy, rd_en, wr_en;
  logic [31:0] rsp_rdata, mem_addr;
  wire  [31:0] bus;

  dm_mem_access_master dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_len_i(req_len),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .rsp_last_o(rsp_last), .busy_o(busy),
    .dm_Mem_rd_en_o(rd_en), .dm_Mem_wr_en_o(wr_en),
    .dm_Mem_rd_address_o(mem_addr), .dm_Mem_rd_wr_data_io(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return (i == 12) ? 32'h0000_0008 : (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  // Data memory attached to the shared bus
  logic [31:0] mem [DEPTH];
  assign bus = (rd_en && mem_addr < DEPTH) ? mem[mem_addr[4:0]] : 'z;
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (wr_en && mem_addr < DEPTH) mem[mem_addr[4:0]] <= bus;
    end
  end

  typedef struct { logic [31:0] rdata; logic err; logic last; int lat; } exp_t;
  typedef struct { logic [31:0] a; logic [31:0] d; } wexp_t;
  exp_t        sb[$];
  wexp_t       wq[$];
  logic [31:0] ref_mem [DEPTH];
  int          n_chk = 0, n_fail = 0;
  bit          stall_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event occurred, none expected", name);
  endtask

  // Request-level reference: what the memory should return for each beat
  task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d, input dm_beat_t len);
    exp_t e;
    wexp_t we;
    if (w) begin
      if (a < DEPTH) begin
        we.a = a; we.d = d; wq.push_back(we);
        ref_mem[a[4:0]] = d;
        e.rdata = '0; e.err = 1'b0; e.last = 1'b1; e.lat = 2;
      end else begin
        e.rdata = '0; e.err = 1'b1; e.last = 1'b1; e.lat = 1;
      end
      sb.push_back(e);
    end else begin
      for (int i = 0; i <= int'(len); i++) begin
        logic [31:0] ba;
        ba = a + 32'(i);
        if (ba >= DEPTH) begin
          e.rdata = '0; e.err = 1'b1; e.last = 1'b1; e.lat = 1;
          sb.push_back(e);
          break;
        end
        e.rdata = ref_mem[ba[4:0]]; e.err = 1'b0; e.last = (i == int'(len)); e.lat = 3;
        sb.push_back(e);
      end
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input dm_beat_t len);
    int waited;
    waited = 0;
    @(posedge clk); #1;
    req_write = w; req_addr = a; req_wdata = d; req_len = len; req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready) begin
      waited++;
      if (waited > 300) begin
        chk("req_accept_timeout", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    model(w, a, d, len);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int waited;
    waited = 0;
    @(negedge clk);
    while (sb.size() != 0 || !req_ready) begin
      waited++;
      if (waited > 500) begin
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
        wq.delete();
        return;
      end
      @(negedge clk);
    end
  endtask

  // Response consumer: random backpressure, or a fixed 4-cycle stall per beat
  initial begin
    int hold_cnt;
    hold_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (stall_mode) begin
        hold_cnt  = rsp_valid ? hold_cnt + 1 : 0;
        rsp_ready = (hold_cnt >= 5);
        if (rsp_ready) hold_cnt = 0;
      end else begin
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor / scoreboard checker, sampling on the falling edge
  initial begin
    int          cyc, ref_cyc;
    bit          prev_hold;
    logic [31:0] p_rdata;
    logic        p_err, p_last;
    exp_t        e;
    wexp_t       w;
    cyc = 0; ref_cyc = 0; prev_hold = 1'b0;
    p_rdata = '0; p_err = 1'b0; p_last = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_hold = 1'b0;
        continue;
      end
      if (rd_en && wr_en) flag("rd_wr_both");
      if (!rd_en && !wr_en) chk("addr_idle_zero", mem_addr, 32'd0);
      if (rd_en && rsp_valid) flag("rsp_during_read");
      if (wr_en) begin
        if (wq.size() == 0) flag("unexpected_write");
        else begin
          w = wq.pop_front();
          chk("wr_addr", mem_addr, w.a);
          chk("wr_bus_data", bus, w.d);
        end
      end
      if (req_valid && req_ready) ref_cyc = cyc;
      if (prev_hold) begin
        chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
        chk("hold_rdata", rsp_rdata, p_rdata);
        chk("hold_err_last", {30'b0, rsp_err, rsp_last}, {30'b0, p_err, p_last});
      end else if (rsp_valid) begin
        if (sb.size() == 0) flag("unexpected_rsp");
        else begin
          e = sb.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
          chk("rsp_last", {31'b0, rsp_last}, {31'b0, e.last});
          chk("rsp_latency", 32'(cyc - ref_cyc), 32'(e.lat));
        end
      end
      if (rsp_valid && rsp_ready && !rsp_last) ref_cyc = cyc;
      prev_hold = rsp_valid && !rsp_ready;
      p_rdata = rsp_rdata; p_err = rsp_err; p_last = rsp_last;
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    #1 rst = 1'b1;
    #20;
    chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_en", {30'b0, rd_en, wr_en}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    issue(1'b1, 32'd5, 32'hDEAD_BEEF, 4'd0);
    issue(1'b0, 32'd12, 32'd0, 4'd0);
    issue(1'b0, 32'd30, 32'd0, 4'd3);
    issue(1'b0, 32'd5, 32'd0, 4'd0);
    wait_done();

    stall_mode = 1'b1;
    issue(1'b0, 32'd3, 32'd0, 4'd2);
    issue(1'b0, 32'd31, 32'd0, 4'd1);
    wait_done();
    stall_mode = 1'b0;

    // Reset in the middle of a write: no memory update, no response
    @(posedge clk); #1;
    req_write = 1'b1; req_addr = 32'd9; req_wdata = 32'h1234_5678; req_len = '0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("pre_rst_wr_en", {31'b0, wr_en}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
    issue(1'b0, 32'd9, 32'd0, 4'd0);
    wait_done();

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      int sel;
      sel = $urandom_range(0, 7);
      if (sel == 0) a = 32'($urandom_range(26, 40));
      else if (sel == 1) a = $urandom;
      else a = 32'($urandom_range(0, DEPTH - 1));
      issue(($urandom_range(0, 2) == 0), a, $urandom, 4'($urandom_range(0, 15)));
    end
    wait_done();
    repeat (3) @(negedge clk);
    chk("final_busy", {31'b0, busy}, 32'd0);
    chk("final_sb_empty", 32'(sb.size() + wq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
